// File: rtl/decode_exec_reg.sv
// Decode-to-execute control pipeline register: stall/flush handling, wrong-path
// squash after a taken PC write, and per-instruction sequence tagging.
module decode_exec_reg #(
    parameter int BRANCH_BUBBLES = 2,
    parameter int SEQ_W          = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             PCSrcE,
    input  logic             ValidD,
    input  logic [3:0]       CondD,
    input  logic [1:0]       FlagWD,
    input  logic             PCSD,
    input  logic             RegWD,
    input  logic             MemWD,
    input  logic             MemtoRegD,
    input  logic             ALUSrcD,
    input  logic [1:0]       ALUControlD,
    input  logic [3:0]       WA3D,
    output logic [3:0]       CondE,
    output logic [1:0]       FlagWE,
    output logic             PCSE,
    output logic             RegWE,
    output logic             MemWE,
    output logic             MemtoRegE,
    output logic             ALUSrcE,
    output logic [1:0]       ALUControlE,
    output logic [3:0]       WA3E,
    output logic             ValidE,
    output logic [SEQ_W-1:0] SeqE,
    output logic             SquashActive
);

    localparam logic [2:0] BUBBLE_RELOAD = 3'(BRANCH_BUBBLES - 1);
    localparam logic [3:0] COND_AL       = 4'b1110;

    logic [SEQ_W-1:0] seq_cnt_r;
    logic [2:0]       bubble_cnt_r;
    logic [2:0]       bubble_next_s;
    logic             taken_s;
    logic             squash_s;
    logic             bubble_s;
    logic             load_s;

    // Next-state decode: a squash source forces a bubble and overrides stall;
    // an empty decode slot also loads a bubble when not stalled.
    always_comb begin
        taken_s       = PCSrcE & ValidE;
        bubble_next_s = bubble_cnt_r;
        if (taken_s) begin
            bubble_next_s = BUBBLE_RELOAD;
        end else if (bubble_cnt_r != 3'd0) begin
            bubble_next_s = bubble_cnt_r - 3'd1;
        end else begin
            bubble_next_s = bubble_cnt_r;
        end
        squash_s = taken_s | FlushE | (bubble_cnt_r != 3'd0);
        bubble_s = squash_s | (~StallE & ~ValidD);
        load_s   = ~squash_s & ~StallE & ValidD;
    end

    // Pipeline register, squash counter and sequence tag counter.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            CondE        <= COND_AL;
            FlagWE       <= 2'b00;
            PCSE         <= 1'b0;
            RegWE        <= 1'b0;
            MemWE        <= 1'b0;
            MemtoRegE    <= 1'b0;
            ALUSrcE      <= 1'b0;
            ALUControlE  <= 2'b00;
            WA3E         <= 4'd0;
            ValidE       <= 1'b0;
            SeqE         <= '0;
            seq_cnt_r    <= '0;
            bubble_cnt_r <= 3'd0;
            SquashActive <= 1'b0;
        end else begin
            bubble_cnt_r <= bubble_next_s;
            SquashActive <= (bubble_next_s != 3'd0);
            if (bubble_s) begin
                // SeqE deliberately keeps the last issued tag across bubbles
                CondE       <= COND_AL;
                FlagWE      <= 2'b00;
                PCSE        <= 1'b0;
                RegWE       <= 1'b0;
                MemWE       <= 1'b0;
                MemtoRegE   <= 1'b0;
                ALUSrcE     <= 1'b0;
                ALUControlE <= 2'b00;
                WA3E        <= 4'd0;
                ValidE      <= 1'b0;
            end else if (load_s) begin
                CondE       <= CondD;
                FlagWE      <= FlagWD;
                PCSE        <= PCSD;
                RegWE       <= RegWD;
                MemWE       <= MemWD;
                MemtoRegE   <= MemtoRegD;
                ALUSrcE     <= ALUSrcD;
                ALUControlE <= ALUControlD;
                WA3E        <= WA3D;
                ValidE      <= 1'b1;
                SeqE        <= seq_cnt_r;
                seq_cnt_r   <= seq_cnt_r + SEQ_W'(1);
            end else begin
                ValidE      <= ValidE;
            end
        end
    end

endmodule

// File: tb/tb_decode_exec_reg.sv
// Directed self-checking bench for decode_exec_reg; a second instance with a
// single squash slot shares all inputs to cover the short-squash case.
module tb_decode_exec_reg;

    logic       CLK = 1'b0;
    logic       Reset, StallE, FlushE, PCSrcE, ValidD;
    logic [3:0] CondD, WA3D;
    logic [1:0] FlagWD, ALUControlD;
    logic       PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD;

    logic [3:0] CondE, WA3E, CondE1, WA3E1;
    logic [1:0] FlagWE, ALUControlE, FlagWE1, ALUControlE1;
    logic       PCSE, RegWE, MemWE, MemtoRegE, ALUSrcE, ValidE, SquashActive;
    logic       PCSE1, RegWE1, MemWE1, MemtoRegE1, ALUSrcE1, ValidE1, SquashActive1;
    logic [7:0] SeqE, SeqE1;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_seq;

    always #5 CLK = ~CLK;

    decode_exec_reg #(.BRANCH_BUBBLES(2), .SEQ_W(8)) dut (
        .CLK(CLK), .Reset(Reset), .StallE(StallE), .FlushE(FlushE), .PCSrcE(PCSrcE),
        .ValidD(ValidD), .CondD(CondD), .FlagWD(FlagWD), .PCSD(PCSD), .RegWD(RegWD),
        .MemWD(MemWD), .MemtoRegD(MemtoRegD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .WA3D(WA3D), .CondE(CondE), .FlagWE(FlagWE), .PCSE(PCSE), .RegWE(RegWE),
        .MemWE(MemWE), .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .WA3E(WA3E), .ValidE(ValidE), .SeqE(SeqE), .SquashActive(SquashActive)
    );

    decode_exec_reg #(.BRANCH_BUBBLES(1), .SEQ_W(8)) dut1 (
        .CLK(CLK), .Reset(Reset), .StallE(StallE), .FlushE(FlushE), .PCSrcE(PCSrcE),
        .ValidD(ValidD), .CondD(CondD), .FlagWD(FlagWD), .PCSD(PCSD), .RegWD(RegWD),
        .MemWD(MemWD), .MemtoRegD(MemtoRegD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .WA3D(WA3D), .CondE(CondE1), .FlagWE(FlagWE1), .PCSE(PCSE1), .RegWE(RegWE1),
        .MemWE(MemWE1), .MemtoRegE(MemtoRegE1), .ALUSrcE(ALUSrcE1), .ALUControlE(ALUControlE1),
        .WA3E(WA3E1), .ValidE(ValidE1), .SeqE(SeqE1), .SquashActive(SquashActive1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Derives every D-side field from the destination register for easy checking
    task automatic drive_d(input logic v, input logic [3:0] w);
        ValidD      = v;
        WA3D        = w;
        CondD       = w + 4'd1;
        FlagWD      = w[1:0];
        PCSD        = 1'b0;
        RegWD       = 1'b1;
        MemWD       = w[0];
        MemtoRegD   = w[1];
        ALUSrcD     = 1'b1;
        ALUControlD = w[1:0];
    endtask

    task automatic check_bubble(input string tag);
        check_eq({tag, "_cond"},  32'(CondE), 32'hE);
        check_eq({tag, "_valid"}, 32'(ValidE), 32'd0);
        check_eq({tag, "_wa3"},   32'(WA3E), 32'd0);
        check_eq({tag, "_en"},    32'({PCSE, RegWE, MemWE, FlagWE, MemtoRegE, ALUSrcE, ALUControlE}), 32'd0);
    endtask

    initial begin
        // Reset with every D input high except the condition field
        Reset = 1'b1; StallE = 1'b1; FlushE = 1'b1; PCSrcE = 1'b1;
        ValidD = 1'b1; CondD = 4'b0000; FlagWD = 2'b11; PCSD = 1'b1; RegWD = 1'b1;
        MemWD = 1'b1; MemtoRegD = 1'b1; ALUSrcD = 1'b1; ALUControlD = 2'b11; WA3D = 4'hF;
        step();
        check_bubble("rst1");
        check_eq("rst1_seq", 32'(SeqE), 32'd0);
        check_eq("rst1_sq",  32'(SquashActive), 32'd0);
        step();
        check_bubble("rst2");
        check_eq("rst2_seq", 32'(SeqE), 32'd0);

        // Three valid loads
        Reset = 1'b0; StallE = 1'b0; FlushE = 1'b0; PCSrcE = 1'b0;
        drive_d(1'b1, 4'd1); step();
        check_eq("ld1_wa3", 32'(WA3E), 32'd1);
        check_eq("ld1_seq", 32'(SeqE), 32'd0);
        check_eq("ld1_valid", 32'(ValidE), 32'd1);
        check_eq("ld1_cond", 32'(CondE), 32'd2);
        check_eq("ld1_fields", 32'({PCSE, RegWE, MemWE, FlagWE, MemtoRegE, ALUSrcE, ALUControlE}), 32'b0_1_1_01_0_1_01);
        drive_d(1'b1, 4'd2); step();
        check_eq("ld2_wa3", 32'(WA3E), 32'd2);
        check_eq("ld2_seq", 32'(SeqE), 32'd1);
        drive_d(1'b1, 4'd3); step();
        check_eq("ld3_wa3", 32'(WA3E), 32'd3);
        check_eq("ld3_seq", 32'(SeqE), 32'd2);

        // Two stalled cycles with changing inputs
        StallE = 1'b1;
        drive_d(1'b1, 4'd4); step();
        check_eq("stl1_wa3", 32'(WA3E), 32'd3);
        check_eq("stl1_seq", 32'(SeqE), 32'd2);
        drive_d(1'b1, 4'd5); step();
        check_eq("stl2_wa3", 32'(WA3E), 32'd3);
        check_eq("stl2_valid", 32'(ValidE), 32'd1);
        StallE = 1'b0;
        drive_d(1'b1, 4'd6); step();
        check_eq("post_stl_wa3", 32'(WA3E), 32'd6);
        check_eq("post_stl_seq", 32'(SeqE), 32'd3);

        // Taken branch: two bubbles (one on the short-squash instance)
        PCSrcE = 1'b1;
        drive_d(1'b1, 4'd7); step();
        check_bubble("br_t");
        check_eq("br_t_seq", 32'(SeqE), 32'd3);
        check_eq("br_t_sq", 32'(SquashActive), 32'd1);
        check_eq("br_t_valid1", 32'(ValidE1), 32'd0);
        check_eq("br_t_sq1", 32'(SquashActive1), 32'd0);
        PCSrcE = 1'b0;
        drive_d(1'b1, 4'd8); step();
        check_bubble("br_t1");
        check_eq("br_t1_sq", 32'(SquashActive), 32'd0);
        check_eq("br_t1_wa3_1", 32'(WA3E1), 32'd8);
        check_eq("br_t1_seq_1", 32'(SeqE1), 32'd4);
        drive_d(1'b1, 4'd9); step();
        check_eq("br_t2_wa3", 32'(WA3E), 32'd9);
        check_eq("br_t2_seq", 32'(SeqE), 32'd4);
        check_eq("br_t2_seq_1", 32'(SeqE1), 32'd5);

        // Taken with stall; squash counter still counts down under stall
        PCSrcE = 1'b1; StallE = 1'b1;
        drive_d(1'b1, 4'd10); step();
        check_bubble("tk_stl");
        check_eq("tk_stl_valid1", 32'(ValidE1), 32'd0);
        check_eq("tk_stl_sq", 32'(SquashActive), 32'd1);
        PCSrcE = 1'b0;
        drive_d(1'b1, 4'd11); step();
        check_bubble("tk_stl2");
        check_eq("tk_stl2_sq", 32'(SquashActive), 32'd0);
        check_eq("tk_stl2_valid1", 32'(ValidE1), 32'd0);
        StallE = 1'b0;
        drive_d(1'b1, 4'd12); step();
        check_eq("tk_rel_wa3", 32'(WA3E), 32'd12);
        check_eq("tk_rel_seq", 32'(SeqE), 32'd5);
        check_eq("tk_rel_seq_1", 32'(SeqE1), 32'd6);

        // Flush together with stall
        FlushE = 1'b1; StallE = 1'b1;
        drive_d(1'b1, 4'd13); step();
        check_bubble("fl_stl");
        check_eq("fl_stl_seq", 32'(SeqE), 32'd5);
        check_eq("fl_stl_valid1", 32'(ValidE1), 32'd0);
        FlushE = 1'b0; StallE = 1'b0;
        drive_d(1'b1, 4'd14); step();
        check_eq("fl_rel_seq", 32'(SeqE), 32'd6);
        check_eq("fl_rel_seq_1", 32'(SeqE1), 32'd7);

        // Empty decode slot, then PCSrcE while E holds a bubble
        drive_d(1'b0, 4'd15); step();
        check_bubble("nov");
        check_eq("nov_seq", 32'(SeqE), 32'd6);
        PCSrcE = 1'b1;
        drive_d(1'b1, 4'd1); step();
        check_eq("pcs_inv_valid", 32'(ValidE), 32'd1);
        check_eq("pcs_inv_seq", 32'(SeqE), 32'd7);
        check_eq("pcs_inv_sq", 32'(SquashActive), 32'd0);
        PCSrcE = 1'b0;

        // Tag wrap: tags 8..255 then 0
        exp_seq = 8;
        for (int i = 0; i < 249; i++) begin
            drive_d(1'b1, 4'(i)); step();
            check_eq("wrap_seq", 32'(SeqE), 32'(exp_seq % 256));
            exp_seq++;
        end
        check_eq("wrap_zero", 32'(SeqE), 32'd0);

        // Reset in the middle of a squash
        PCSrcE = 1'b1; step();
        check_eq("mid_sq", 32'(SquashActive), 32'd1);
        PCSrcE = 1'b0; Reset = 1'b1; step();
        check_bubble("mid_rst");
        check_eq("mid_rst_sq", 32'(SquashActive), 32'd0);
        check_eq("mid_rst_seq", 32'(SeqE), 32'd0);
        Reset = 1'b0;
        drive_d(1'b1, 4'd5); step();
        check_eq("after_rst_wa3", 32'(WA3E), 32'd5);
        check_eq("after_rst_seq", 32'(SeqE), 32'd0);
        check_eq("after_rst_valid", 32'(ValidE), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
